// File: rtl/nor_gate.sv
// NOR gate with a registered copy, a saturating rise counter and an optional
// self-check (macro NOR_GATE_CHECK_EN) comparing three realisations of the NOR.
module nor_gate #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             cnt_clr,
  input  logic             err_clr,
  output logic             out,
  output logic             out_q,
  output logic [CNT_W-1:0] rise_cnt,
  output logic             mismatch,
  output logic             err_sticky
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             w_proc;
  logic             w_rise;
  logic             r_out_q;
  logic [CNT_W-1:0] r_cnt;

  always_comb begin
    w_proc = 1'b0;
    case ({a, b})
      2'b00:   w_proc = 1'b1;
      2'b01:   w_proc = 1'b0;
      2'b10:   w_proc = 1'b0;
      2'b11:   w_proc = 1'b0;
      default: w_proc = 1'b0;
    endcase
  end

  assign out    = w_proc;
  assign w_rise = w_proc & ~r_out_q;

  // Clear takes priority over an increment; the counter never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_q <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_out_q <= w_proc;
      if (cnt_clr)
        r_cnt <= '0;
      else if (w_rise && (r_cnt != CNT_MAX))
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign out_q    = r_out_q;
  assign rise_cnt = r_cnt;

`ifdef NOR_GATE_CHECK_EN
  logic w_data;
  logic w_gate;
  logic w_mis;
  logic r_err;

  assign w_data = ~(a | b);
  nor u_nor (w_gate, a, b);
  assign w_mis  = (w_proc != w_data) | (w_proc != w_gate) | (w_data != w_gate);

  // A mismatch on the same edge as err_clr keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_err <= 1'b0;
    else if (w_mis)
      r_err <= 1'b1;
    else if (err_clr)
      r_err <= 1'b0;
  end

  assign mismatch   = w_mis;
  assign err_sticky = r_err;
`else
  // err_clr has no effect here; it is only referenced so the port stays live.
  assign mismatch   = 1'b0 & err_clr;
  assign err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_nor_gate.sv
// Scoreboard bench for nor_gate: an 8-bit and a 2-bit counter instance share inputs.
module tb_nor_gate;

`ifdef NOR_GATE_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk, rst_n, a, b, cnt_clr, err_clr;
  logic out, out_q, mismatch, err_sticky;
  logic [7:0] rise_cnt;
  logic out2, out_q2, mismatch2, err_sticky2;
  logic [1:0] rise_cnt2;
  logic f_val;

  int n_total = 0;
  int n_bad   = 0;

  // {out_q, cnt8, cnt2, err}
  logic [11:0] exp_q[$];
  logic       m_outq;
  logic [7:0] m_cnt8;
  logic [1:0] m_cnt2;
  logic       m_err;

  nor_gate #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cnt_clr(cnt_clr), .err_clr(err_clr),
    .out(out), .out_q(out_q), .rise_cnt(rise_cnt), .mismatch(mismatch),
    .err_sticky(err_sticky)
  );

  nor_gate #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cnt_clr(cnt_clr), .err_clr(err_clr),
    .out(out2), .out_q(out_q2), .rise_cnt(rise_cnt2), .mismatch(mismatch2),
    .err_sticky(err_sticky2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_outq = 1'b0;
    m_cnt8 = '0;
    m_cnt2 = '0;
    m_err  = 1'b0;
  endtask

  // One cycle: drive at negedge, check combinational outputs, push the
  // expected registered state, then pop and compare after the rising edge.
  task automatic step(input logic na, input logic nb, input logic nclr,
                      input logic neclr, input logic nmis);
    logic nor_v, rise, mis_eff;
    logic [11:0] e;
    @(negedge clk);
    a = na; b = nb; cnt_clr = nclr; err_clr = neclr;
`ifdef NOR_GATE_CHECK_EN
    if (nmis) begin
      f_val = na | nb;
      force dut.w_gate = f_val;
    end
`endif
    #1;
    nor_v   = ~(na | nb);
    mis_eff = nmis & CHK;
    check("out", {31'd0, out}, {31'd0, nor_v});
    check("out2", {31'd0, out2}, {31'd0, nor_v});
    check("mismatch", {31'd0, mismatch}, {31'd0, mis_eff});
    check("mismatch2", {31'd0, mismatch2}, 32'd0);
    rise = nor_v & ~m_outq;
    if (nclr) begin
      m_cnt8 = '0;
      m_cnt2 = '0;
    end else if (rise) begin
      if (m_cnt8 != 8'hff) m_cnt8 = m_cnt8 + 8'd1;
      if (m_cnt2 != 2'h3)  m_cnt2 = m_cnt2 + 2'd1;
    end
    if (mis_eff)     m_err = 1'b1;
    else if (neclr)  m_err = 1'b0;
    m_outq = nor_v;
    exp_q.push_back({m_outq, m_cnt8, m_cnt2, m_err});
    @(posedge clk);
    #1;
`ifdef NOR_GATE_CHECK_EN
    if (nmis) release dut.w_gate;
`endif
    if (exp_q.size() == 0) begin
      check("queue_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check("out_q", {31'd0, out_q}, {31'd0, e[11]});
      check("out_q2", {31'd0, out_q2}, {31'd0, e[11]});
      check("rise_cnt", {24'd0, rise_cnt}, {24'd0, e[10:3]});
      check("rise_cnt2", {30'd0, rise_cnt2}, {30'd0, e[2:1]});
      check("err_sticky", {31'd0, err_sticky}, {31'd0, e[0]});
      check("err_sticky2", {31'd0, err_sticky2}, 32'd0);
    end
  endtask

  task automatic check_regs_zero(input string tag);
    check({tag, "_out_q"}, {31'd0, out_q}, 32'd0);
    check({tag, "_cnt"}, {24'd0, rise_cnt}, 32'd0);
    check({tag, "_cnt2"}, {30'd0, rise_cnt2}, 32'd0);
    check({tag, "_err"}, {31'd0, err_sticky}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; a = 1'b0; b = 1'b0; cnt_clr = 1'b0; err_clr = 1'b0; f_val = 1'b0;
    model_reset();
    #12;
    check_regs_zero("reset");
    check("reset_out", {31'd0, out}, 32'd1);
    @(posedge clk); #2;
    check_regs_zero("reset_hold");
    rst_n = 1'b1;

    // First edge after release with a=b=0 gives out_q=1 and one count.
    step(0, 0, 0, 0, 0);
    check("release_cnt", {24'd0, rise_cnt}, 32'd1);
    step(0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);

    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
    end
    check("rise_total", {24'd0, rise_cnt}, 32'd6);
    check("sat_cnt2", {30'd0, rise_cnt2}, 32'd3);
    step(1, 1, 0, 0, 0);
    check("sat_hold", {30'd0, rise_cnt2}, 32'd3);

    // Clear coincides with a rise.
    step(0, 0, 1, 0, 0);
    check("clr_win", {24'd0, rise_cnt}, 32'd0);
    check("clr_win2", {30'd0, rise_cnt2}, 32'd0);

    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
    end
    check("pre_rst_cnt2", {30'd0, rise_cnt2}, 32'd3);
    check("pre_rst_outq", {31'd0, out_q}, 32'd1);

    // Asynchronous reset between edges.
    #2;
    rst_n = 1'b0;
    #1;
    check_regs_zero("async");
    a = 1'b1;
    #1;
    check("rst_out_comb0", {31'd0, out}, 32'd0);
    a = 1'b0;
    #1;
    check("rst_out_comb1", {31'd0, out}, 32'd1);
    @(posedge clk); #1;
    check_regs_zero("async_hold");
    a = 1'b1;
    rst_n = 1'b1;
    model_reset();

    // Check path: faulted gate net for one edge, then clear scenarios.
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0);

    for (int i = 0; i < 30; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 5) == 0));
    end

    check("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/nor_gate.md
NOR_GATE -- requirements
Module: nor_gate

Interface
REQ-001 The module SHALL have parameter CNT_W, default 8, giving the width of the rise counter (legal range 1..32).
REQ-002 The module SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 The module SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The module SHALL have port a  input  1  NOR operand A.
REQ-005 The module SHALL have port b  input  1  NOR operand B.
REQ-006 The module SHALL have port cnt_clr  input  1  synchronous clear of rise_cnt.
REQ-007 The module SHALL have port err_clr  input  1  synchronous clear of err_sticky.
REQ-008 The module SHALL have port out  output  1  combinational NOR of a and b.
REQ-009 The module SHALL have port out_q  output  1  out registered once.
REQ-010 The module SHALL have port rise_cnt  output  CNT_W  saturating count of out_q 0->1 transitions.
REQ-011 The module SHALL have port mismatch  output  1  combinational disagreement between internal realisations.
REQ-012 The module SHALL have port err_sticky  output  1  latched mismatch indication.

Function
REQ-013 out SHALL equal ~(a | b) with zero latency: 00->1, 01->0, 10->0, 11->0.
REQ-014 The NOR SHALL be realised three ways internally: continuous-assignment expression, gate-primitive instance, and combinational procedural block with a full case over {a,b}.
REQ-015 out SHALL be driven by the procedural realisation.
REQ-016 out_q SHALL capture out on every rising clk edge (latency 1 cycle).
REQ-017 rise_cnt SHALL increment by 1 on an edge where out==1 and out_q==0, i.e. the edge at which out_q rises.
REQ-018 rise_cnt SHALL saturate at 2^CNT_W-1 and hold there; it SHALL never wrap.
REQ-019 cnt_clr SHALL set rise_cnt to 0 on the next edge; clear SHALL win over a simultaneous increment.
REQ-020 mismatch SHALL be 1 whenever any two of the three realisations differ, else 0.
REQ-021 err_sticky SHALL set on an edge where mismatch==1 and hold until cleared.
REQ-022 err_clr SHALL clear err_sticky on the next edge; a simultaneous mismatch SHALL win, leaving err_sticky at 1.
REQ-023 Input changes between edges SHALL affect out and mismatch immediately and registered outputs only at the next edge.

Reset
REQ-024 On rst_n low, out_q, rise_cnt and err_sticky SHALL go to 0 immediately, independent of clk.
REQ-025 While rst_n is low, registered outputs SHALL hold reset values; out and mismatch SHALL remain combinational.
REQ-026 Reset asserted mid-operation SHALL discard any pending increment or sticky set.
REQ-027 On the first edge after rst_n rises with a=b=0, out_q SHALL go to 1 and rise_cnt SHALL go to 1.

Configuration
REQ-028 Macro NOR_GATE_CHECK_EN SHALL compile in the dataflow and gate-level realisations, the comparator, and the err_sticky register.
REQ-029 Without NOR_GATE_CHECK_EN, only the procedural realisation SHALL exist.
REQ-030 Without NOR_GATE_CHECK_EN, mismatch and err_sticky SHALL be tied to 0, with ports retained and err_clr ignored.

Verification
REQ-031 Truth table: drive {a,b}=00,01,10,11 at 10-unit steps -> out=1,0,0,0; out_q follows one edge later; mismatch=0 throughout.
REQ-032 Rise counting: toggle a 0/1 five times with b=0, one edge per phase -> rise_cnt=5 (the reset release yields 1 extra if starting at 00, so expect 6 in that case).
REQ-033 Saturation with CNT_W=2: produce 5 out_q rises -> rise_cnt=3 and holds; assert cnt_clr together with a rise -> rise_cnt=0.
REQ-034 Async reset: with rise_cnt=3 and out_q=1, pull rst_n low between edges -> out_q=0, rise_cnt=0 before the next edge.
REQ-035 Check path (macro on): force the gate-level net to the wrong value for one edge -> mismatch=1, err_sticky=1 and held; err_clr with no mismatch -> 0; err_clr with mismatch -> stays 1.
REQ-036 Macro off: run the same force scenario -> mismatch=0 and err_sticky=0 always.
